// File: rtl/uart_rx_param.sv
// ----------------------------------------------------------------------------
// uart_rx_param
//
// Parameterised UART receiver. Oversamples an asynchronous serial line with a
// per-bit counter, assembles DATA_BITS data bits LSB-first and checks
// STOP_BITS stop bits (and, optionally, one parity bit). Each completed frame is
// handed to the consumer through a single holding register with a level-valid
// flag and explicit acknowledge.
//
// Optional feature:
//   UART_RX_PARITY_EN  defined   -> a parity bit follows the data bits and is
//                                   checked (even, or odd when PARITY_ODD = 1).
//                      undefined -> frame is start + data + stop;
//                                   o_parity_err is constant 0.
//
// Parameters:
//   CLK_PER_BIT  clock cycles per bit period (4..65535)
//   DATA_BITS    data bits per frame (5..8)
//   STOP_BITS    stop bits checked per frame (1 or 2)
//   PARITY_ODD   0 = even parity, 1 = odd parity
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_rx_serial   serial line, idle high, asynchronous to i_clk
//   i_rx_ack      consumer acknowledge; clears o_rx_dv and all flags
//   o_rx_data     held byte, bits above DATA_BITS-1 are zero
//   o_rx_dv       held byte not yet acknowledged
//   o_frame_err   held byte's frame had a low stop sample
//   o_parity_err  held byte's frame had a parity mismatch
//   o_overrun     sticky: a frame completed while o_rx_dv was high
//   o_busy        receiver is inside a frame (FSM not idle)
// ----------------------------------------------------------------------------
module uart_rx_param #(
    parameter int unsigned CLK_PER_BIT = 868,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned PARITY_ODD  = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_serial,
    input  logic       i_rx_ack,
    output logic [7:0] o_rx_data,
    output logic       o_rx_dv,
    output logic       o_frame_err,
    output logic       o_parity_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int unsigned   CntW     = $clog2(CLK_PER_BIT);
    localparam logic [CntW-1:0] CntBit  = CntW'(CLK_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'((CLK_PER_BIT - 1) / 2);
    localparam logic [2:0]    LastData = 3'(DATA_BITS - 1);
    localparam logic          LastStop = 1'(STOP_BITS - 1);
    localparam logic          ParOdd   = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
`ifdef UART_RX_PARITY_EN
        StParity   = 3'd3,
`endif
        StStop     = 3'd4,
        StWaitHigh = 3'd5
    } state_e;

    state_e          state_q;
    logic [1:0]      sync_q;
    logic [1:0]      vld_q;      // fills with ones once the synchroniser holds real line data
    logic            armed_q;    // line has been seen high since reset
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic            stop_idx_q;
    logic [7:0]      shift_q;
    logic            ferr_q;     // framing error of the frame in flight
    logic            deliver_q;  // final stop sampled last cycle
    logic [7:0]      data_q;
    logic            dv_q;
    logic            frame_err_q;
    logic            overrun_q;
`ifdef UART_RX_PARITY_EN
    logic            perr_q;
    logic            parity_err_q;
`endif

    logic rx;
    assign rx = sync_q[1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            sync_q       <= 2'b11;
            vld_q        <= 2'b00;
            armed_q      <= 1'b0;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            stop_idx_q   <= 1'b0;
            shift_q      <= 8'h00;
            ferr_q       <= 1'b0;
            deliver_q    <= 1'b0;
            data_q       <= 8'h00;
            dv_q         <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q       <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[0], i_rx_serial};
            vld_q     <= {vld_q[0], 1'b1};
            deliver_q <= 1'b0;
            // A line already low when reset releases is not a falling edge;
            // require a genuine high level first.
            if (vld_q[1] && rx) begin
                armed_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (armed_q && !rx) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == CntHalf) begin
                        cnt_q <= '0;
                        if (!rx) begin
                            state_q   <= StData;
                            bit_idx_q <= 3'd0;
                            shift_q   <= 8'h00;
                            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            perr_q    <= 1'b0;
`endif
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == CntBit) begin
                        cnt_q              <= '0;
                        shift_q[bit_idx_q] <= rx;
                        if (bit_idx_q == LastData) begin
                            stop_idx_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            state_q    <= StParity;
`else
                            state_q    <= StStop;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (cnt_q == CntBit) begin
                        cnt_q      <= '0;
                        stop_idx_q <= 1'b0;
                        state_q    <= StStop;
                        if (rx != ((^shift_q) ^ ParOdd)) begin
                            perr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
`endif
                StStop: begin
                    if (cnt_q == CntBit) begin
                        cnt_q <= '0;
                        if (!rx) begin
                            ferr_q <= 1'b1;
                        end
                        if (stop_idx_q == LastStop) begin
                            deliver_q <= 1'b1;
                            // A low stop may be a break: stay out of IDLE until
                            // the line returns high.
                            state_q   <= (!rx || ferr_q) ? StWaitHigh : StIdle;
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWaitHigh: begin
                    cnt_q <= '0;
                    if (rx) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Holding register. An ack in the delivery cycle retires the old
            // byte, so the new one takes its place without an overrun.
            if (deliver_q) begin
                if (!dv_q || i_rx_ack) begin
                    data_q       <= shift_q;
                    frame_err_q  <= ferr_q;
`ifdef UART_RX_PARITY_EN
                    parity_err_q <= perr_q;
`endif
                    dv_q         <= 1'b1;
                    if (i_rx_ack) begin
                        overrun_q <= 1'b0;
                    end
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (i_rx_ack && dv_q) begin
                dv_q         <= 1'b0;
                frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= 1'b0;
`endif
                overrun_q    <= 1'b0;
            end
        end
    end

    assign o_rx_data   = data_q;
    assign o_rx_dv     = dv_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
    assign o_busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parity_err_q;
`else
    // Parity sense is meaningless without the parity stage; the flag is constant 0.
    assign o_parity_err = ParOdd & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

    localparam int Cpb    = 16;
    localparam int ParOdd = 0;
`ifdef UART_RX_PARITY_EN
    localparam bit ParEn = 1'b1;
`else
    localparam bit ParEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n_a = 1'b0, rst_n_b = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       ack_a = 1'b0, ack_b = 1'b0;
    logic [7:0] data_a, data_b;
    logic       dv_a, ferr_a, perr_a, ovr_a, busy_a;
    logic       dv_b, ferr_b, perr_b, ovr_b, busy_b;

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_PER_BIT(Cpb), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(ParOdd)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n_a), .i_rx_serial(rx_a), .i_rx_ack(ack_a),
        .o_rx_data(data_a), .o_rx_dv(dv_a), .o_frame_err(ferr_a),
        .o_parity_err(perr_a), .o_overrun(ovr_a), .o_busy(busy_a)
    );

    uart_rx_param #(
        .CLK_PER_BIT(Cpb), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(ParOdd)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n_b), .i_rx_serial(rx_b), .i_rx_ack(ack_b),
        .o_rx_data(data_b), .o_rx_dv(dv_b), .o_frame_err(ferr_b),
        .o_parity_err(perr_b), .o_overrun(ovr_b), .o_busy(busy_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model of dut_a's holding register.
    logic [7:0] exp_data = 8'h00;
    logic       exp_dv = 1'b0, exp_ferr = 1'b0, exp_perr = 1'b0, exp_ovr = 1'b0;

    task automatic model_frame(input logic [7:0] d, input logic fe, input logic pe);
        if (exp_dv) begin
            exp_ovr = 1'b1;
        end else begin
            exp_data = d;
            exp_ferr = fe;
            exp_perr = pe;
            exp_dv   = 1'b1;
        end
    endtask

    task automatic model_ack();
        if (exp_dv) begin
            exp_dv   = 1'b0;
            exp_ferr = 1'b0;
            exp_perr = 1'b0;
            exp_ovr  = 1'b0;
        end
    endtask

    task automatic check_a(input string tag);
        check({tag, "_dv"},   32'(dv_a),   32'(exp_dv));
        check({tag, "_data"}, 32'(data_a), 32'(exp_data));
        check({tag, "_ferr"}, 32'(ferr_a), 32'(exp_ferr));
        check({tag, "_perr"}, 32'(perr_a), 32'(exp_perr));
        check({tag, "_ovr"},  32'(ovr_a),  32'(exp_ovr));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input int tgt, input logic v);
        if (tgt == 0) rx_a = v;
        else          rx_b = v;
    endtask

    task automatic pulse_ack(input int tgt);
        if (tgt == 0) ack_a = 1'b1;
        else          ack_b = 1'b1;
        wait_cycles(1);
        ack_a = 1'b0;
        ack_b = 1'b0;
    endtask

    // One full frame; the line is left at end_val afterwards.
    task automatic send_frame(input int tgt, input logic [7:0] d, input int nbits,
                              input int nstop, input logic stop_val,
                              input logic par_flip, input logic end_val);
        logic p;
        p = (ParOdd != 0) ^ par_flip;
        set_line(tgt, 1'b0);
        wait_cycles(Cpb);
        for (int i = 0; i < nbits; i++) begin
            set_line(tgt, d[i]);
            p = p ^ d[i];
            wait_cycles(Cpb);
        end
        if (ParEn) begin
            set_line(tgt, p);
            wait_cycles(Cpb);
        end
        for (int s = 0; s < nstop; s++) begin
            set_line(tgt, stop_val);
            wait_cycles(Cpb);
        end
        set_line(tgt, end_val);
    endtask

    logic [7:0] rd;
    logic       rse, rpf;
    int         gap;

    initial begin
        wait_cycles(3);
        check_a("reset");
        check("reset_busy_a", 32'(busy_a), 32'd0);
        check("reset_busy_b", 32'(busy_b), 32'd0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        wait_cycles(6);

        // Basic 8N1 frame.
        send_frame(0, 8'h55, 8, 1, 1'b1, 1'b0, 1'b1);
        model_frame(8'h55, 1'b0, 1'b0);
        check_a("b55");
        check("b55_busy", 32'(busy_a), 32'd0);
        pulse_ack(0);
        model_ack();
        check_a("b55_ack");

        // Short low glitch is rejected at the start-bit centre.
        rx_a = 1'b0;
        wait_cycles(4);
        rx_a = 1'b1;
        wait_cycles(2);
        check("glitch_busy", 32'(busy_a), 32'd1);
        wait_cycles(30);
        check("glitch_idle", 32'(busy_a), 32'd0);
        check_a("glitch");

        // Low stop bit followed by a long break: one delivery only.
        send_frame(0, 8'hA3, 8, 1, 1'b0, 1'b0, 1'b0);
        model_frame(8'hA3, 1'b1, 1'b0);
        wait_cycles(50 * Cpb);
        check("break_busy", 32'(busy_a), 32'd1);
        check_a("break");
        rx_a = 1'b1;
        wait_cycles(8);
        check("break_idle", 32'(busy_a), 32'd0);
        check_a("break_end");
        pulse_ack(0);
        model_ack();

        if (ParEn) begin
            // Even parity of 0x07 is 1; flipping sends 0.
            send_frame(0, 8'h07, 8, 1, 1'b1, 1'b1, 1'b1);
            model_frame(8'h07, 1'b0, 1'b1);
            check_a("par07");
            pulse_ack(0);
            model_ack();
        end

        // Two back-to-back frames without ack.
        send_frame(0, 8'h11, 8, 1, 1'b1, 1'b0, 1'b1);
        model_frame(8'h11, 1'b0, 1'b0);
        send_frame(0, 8'h22, 8, 1, 1'b1, 1'b0, 1'b1);
        model_frame(8'h22, 1'b0, 1'b0);
        check_a("ovr");
        wait_cycles(3);
        pulse_ack(0);
        model_ack();
        check_a("ovr_ack");
        wait_cycles(4);

        // Randomised frames, gaps and acks.
        for (int it = 0; it < 40; it++) begin
            rd  = 8'($urandom);
            rse = ($urandom_range(0, 5) == 0);
            rpf = ParEn && ($urandom_range(0, 4) == 0);
            send_frame(0, rd, 8, 1, !rse, rpf, 1'b1);
            model_frame(rd, rse, rpf);
            check_a("rnd");
            gap = rse ? 20 + int'($urandom_range(0, 20)) : int'($urandom_range(0, 40));
            if (gap >= 2 && $urandom_range(0, 1) == 1) begin
                pulse_ack(0);
                model_ack();
                check_a("rnd_ack");
                gap = gap - 1;
            end
            wait_cycles(gap);
        end

        // 5 data bits, 2 stop bits.
        send_frame(1, 8'h1F, 5, 2, 1'b1, 1'b0, 1'b1);
        check("b1f_data", 32'(data_b), 32'h1F);
        check("b1f_dv",   32'(dv_b),   32'd1);
        check("b1f_ferr", 32'(ferr_b), 32'd0);
        check("b1f_perr", 32'(perr_b), 32'd0);

        // Reset mid-data with the line held low across release.
        rx_b = 1'b0;
        wait_cycles(Cpb);
        wait_cycles(Cpb + Cpb / 2);
        check("mid_busy", 32'(busy_b), 32'd1);
        rst_n_b = 1'b0;
        wait_cycles(2);
        check("rst_data", 32'(data_b), 32'h00);
        check("rst_dv",   32'(dv_b),   32'd0);
        check("rst_busy", 32'(busy_b), 32'd0);
        rst_n_b = 1'b1;
        wait_cycles(3 * Cpb);
        check("rst_low_idle", 32'(busy_b), 32'd0);
        check("rst_low_dv",   32'(dv_b),   32'd0);
        rx_b = 1'b1;
        wait_cycles(2 * Cpb);
        send_frame(1, 8'h0A, 5, 2, 1'b1, 1'b0, 1'b1);
        check("b0a_data", 32'(data_b), 32'h0A);
        check("b0a_dv",   32'(dv_b),   32'd1);
        check("b0a_ferr", 32'(ferr_b), 32'd0);
        check("b0a_ovr",  32'(ovr_b),  32'd0);
        pulse_ack(1);
        check("b0a_ack",  32'(dv_b),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter CLK_PER_BIT, default 868; clocks per bit period (i_clk / baud), legal range 4..65535.
REQ-002 Parameter DATA_BITS, default 8; data bits per frame, legal 5..8.
REQ-003 Parameter STOP_BITS, default 1; stop bits checked per frame, legal 1 or 2.
REQ-004 Parameter PARITY_ODD, default 0; 0 = even parity, 1 = odd (used only when parity compiled in).
REQ-005 i_clk  input  1  single system clock, all logic on rising edge.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_rx_serial  input  1  asynchronous serial line, idle high.
REQ-008 i_rx_ack  input  1  consumer acknowledge, clears o_rx_dv and error flags.
REQ-009 o_rx_data  output  8  received byte, LSB-first assembly, bits [7:DATA_BITS] zero.
REQ-010 o_rx_dv  output  1  level: byte held in o_rx_data not yet acknowledged.
REQ-011 o_frame_err  output  1  stop bit sampled low in held byte's frame.
REQ-012 o_parity_err  output  1  parity mismatch in held byte's frame.
REQ-013 o_overrun  output  1  sticky: a frame completed while o_rx_dv was high.
REQ-014 o_busy  output  1  high whenever FSM is not IDLE.

Function
REQ-015 i_rx_serial SHALL pass a 2-flop synchroniser (reset value 1) before any use; all timing below is relative to the synchronised line.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; bit counter width $clog2(CLK_PER_BIT).
REQ-017 IDLE: counter cleared; synchronised line low SHALL move to START.
REQ-018 START: after (CLK_PER_BIT-1)/2 cycles line resampled; low -> DATA with counter cleared; high -> IDLE (glitch rejected, no flags).
REQ-019 DATA: each bit sampled after CLK_PER_BIT cycles into index 0..DATA_BITS-1; after last bit -> PARITY if compiled in, else STOP.
REQ-020 PARITY: bit sampled after CLK_PER_BIT cycles; mismatch vs XOR of data bits (inverted when PARITY_ODD=1) latches a frame parity error.
REQ-021 STOP: each of STOP_BITS sampled after CLK_PER_BIT cycles; any low sample latches a frame framing error.
REQ-022 After final stop sample: framing error -> WAIT_HIGH, else -> IDLE; WAIT_HIGH stays until line high, then IDLE (break condition never retriggers START).
REQ-023 Delivery on cycle after final stop sample: if o_rx_dv low, o_rx_data, o_frame_err, o_parity_err load and o_rx_dv sets (1-cycle latency).
REQ-024 If o_rx_dv high at delivery: new frame discarded, o_rx_data unchanged, o_overrun set.
REQ-025 i_rx_ack high SHALL clear o_rx_dv, o_frame_err, o_parity_err, o_overrun next cycle; ack with o_rx_dv low is ignored.
REQ-026 Ack and delivery in same cycle: ack applies to old byte, new byte loads, o_rx_dv remains 1, o_overrun not set.
REQ-027 Reception SHALL continue independently of o_rx_dv; back-to-back frames with no idle gap are received.

Reset
REQ-028 i_rst_n low SHALL asynchronously force IDLE, counters 0, synchroniser 1, o_rx_data 0, all flags 0, o_busy 0.
REQ-029 Reset mid-frame SHALL abandon the frame; after release, reception restarts only on a fresh falling edge.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: PARITY state and parity check present per REQ-020.
REQ-031 Macro undefined: no PARITY state, frame is start+data+stop, o_parity_err tied 0, PARITY_ODD ignored.

Verification
REQ-032 CLK_PER_BIT=16, 8N1, send 0x55 -> o_rx_data=0x55, o_rx_dv=1 one cycle after stop centre, no flags.
REQ-033 Low glitch of 4 cycles on idle line -> FSM returns to IDLE, o_rx_dv stays 0.
REQ-034 Send 0xA3 with stop bit low, then hold line low 50 bit times -> o_frame_err=1, single delivery, no second frame until line high.
REQ-035 Parity enabled, even, send 0x07 with parity bit 0 -> o_parity_err=1, o_rx_data=0x07.
REQ-036 Send 0x11 then 0x22 without ack -> o_rx_data=0x11, o_overrun=1; ack -> all flags 0.
REQ-037 DATA_BITS=5, STOP_BITS=2, send 0x1F -> o_rx_data=0x1F; assert i_rst_n low mid-data -> outputs 0, next frame 0x0A received correctly.
